hi_lo_register_unit: RTL

- Downstream consumer of the EX-stage ALU's 64-bit result: holds the architectural HI/LO register pair.
- Implements MULT write-back, MADD/MSUB multi-cycle accumulate, MTHI/MTLO writes and MFHI/MFLO reads.
- Asserts Stall to the pipeline hazard logic while an accumulate is in flight.

---
 rtl/hi_lo_register_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/hi_lo_register_unit.sv
// HI/LO architectural register pair: MULT write-back, multi-cycle MADD/MSUB accumulate,
// MTHI/MTLO writes and registered MFHI/MFLO reads with a one-cycle valid pulse.
//
// state | meaning
// IDLE  | accepting ops from the pipeline
// ACC   | accumulate pending, Stall high, counter running down to commit
module hi_lo_register_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_CYCLES = 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    OpValid,
    input  logic [2:0]              Op,
    input  logic [2*DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0]   RsData,
    output logic                    Stall,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    ReadValid,
    output logic [DATA_WIDTH-1:0]   HI,
    output logic [DATA_WIDTH-1:0]   LO
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_MADD = 3'b010;
    localparam logic [2:0] OP_MSUB = 3'b011;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [2:0] OP_MFHI = 3'b110;
    localparam logic [2:0] OP_MFLO = 3'b111;

    // ACC_CYCLES is limited to 1..15, so four bits always hold the reload value
    localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

    logic [0:0]              state;
    logic [3:0]              count;
    logic                    acc_sub;
    logic [2*DATA_WIDTH-1:0] product;
    logic [2*DATA_WIDTH-1:0] hi_lo;
    logic [2*DATA_WIDTH-1:0] acc_result;

    assign hi_lo      = {HI, LO};
    assign acc_result = acc_sub ? (hi_lo - product) : (hi_lo + product);
    assign Stall      = (state == ACC);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            acc_sub   <= 1'b0;
            product   <= '0;
            HI        <= '0;
            LO        <= '0;
            ReadData  <= '0;
            ReadValid <= 1'b0;
        end else begin
            ReadValid <= 1'b0;
            case (state)
                IDLE: begin
                    // Op is only examined when OpValid is set, so an undriven Op is harmless
                    if (OpValid) begin
                        case (Op)
                            OP_MULT: {HI, LO} <= ALUResult;
                            OP_MADD, OP_MSUB: begin
                                product <= ALUResult;
                                acc_sub <= (Op == OP_MSUB);
                                count   <= CNT_INIT;
                                state   <= ACC;
                            end
                            OP_MTHI: HI <= RsData;
                            OP_MTLO: LO <= RsData;
                            OP_MFHI: begin
                                ReadData  <= HI;
                                ReadValid <= 1'b1;
                            end
                            OP_MFLO: begin
                                ReadData  <= LO;
                                ReadValid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ACC: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        {HI, LO} <= acc_result;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
